// File: rtl/instr_injector.sv
// Instruction injector: buffers host-loaded instructions in a small FIFO and
// drives them into the CPU instruction input one per clock while in RUN.
// It watches CPU halt and PC, and trips a watchdog if the program never halts.
module instr_injector #(
    parameter int unsigned    DEPTH      = 16,
    parameter int unsigned    IW         = 16,
    parameter logic [IW-1:0]  FILL_INSTR = '0,
    parameter int unsigned    TIMEOUT    = 100000,
    parameter int unsigned    CW         = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_valid,
    input  logic [IW-1:0] ld_instr,
    output logic          ld_ready,
    input  logic          start,
    input  logic          clear,
    output logic [IW-1:0] instr_out,
    output logic          mode_out,
    input  logic [15:0]   pc_in,
    input  logic          hlt_in,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [15:0]   halt_pc,
    output logic [15:0]   issued_cnt,
    output logic [CW-1:0] cycle_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StHalted, StTimeout} state_e;

    state_e state_q, state_d;

    logic [IW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          full, empty, push, pop, last_cycle;

    logic [IW-1:0] instr_q, instr_d;
    logic          mode_q, mode_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;
    logic [15:0]   halt_pc_q, halt_pc_d;
    logic [15:0]   issued_q, issued_d;
    logic [CW-1:0] cycle_q, cycle_d;

    assign full       = (count_q == (AW + 1)'(DEPTH));
    assign empty      = (count_q == '0);
    assign ld_ready   = !full;
    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign push       = ld_valid && !full && !clear;
    assign last_cycle = (cycle_q == CW'(TIMEOUT - 1));
    assign pop        = (state_q == StRun) && !clear && !hlt_in && !last_cycle && !empty;

    // FIFO storage write port (no reset needed on the data array)
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ld_instr;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (AW + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (AW + 1)'(1);
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides everything
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !empty) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (hlt_in) begin
                        state_d = StHalted;
                    end else if (last_cycle) begin
                        state_d = StTimeout;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Next values of the registered outputs
    always_comb begin
        instr_d   = FILL_INSTR;
        mode_d    = 1'b0;
        halt_pc_d = halt_pc_q;
        issued_d  = issued_q;
        cycle_d   = cycle_q;
        busy_d    = (state_d == StRun);
        done_d    = (state_d == StHalted);
        timeout_d = (state_d == StTimeout);
        if (clear) begin
            halt_pc_d = '0;
            issued_d  = '0;
            cycle_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (state_d == StRun) begin
                        issued_d = '0;
                        cycle_d  = '0;
                    end
                end
                StRun: begin
                    cycle_d = (cycle_q == CW'(TIMEOUT)) ? cycle_q : cycle_q + CW'(1);
                    if (hlt_in) begin
                        halt_pc_d = pc_in;
                    end else if (!last_cycle) begin
                        // mode rises together with the first injected instruction
                        mode_d = 1'b1;
                        if (!empty) begin
                            instr_d  = mem_q[rd_ptr_q];
                            issued_d = issued_q + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q   <= FILL_INSTR;
            mode_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            halt_pc_q <= '0;
            issued_q  <= '0;
            cycle_q   <= '0;
        end else begin
            instr_q   <= instr_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            halt_pc_q <= halt_pc_d;
            issued_q  <= issued_d;
            cycle_q   <= cycle_d;
        end
    end

    assign instr_out  = instr_q;
    assign mode_out   = mode_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign halt_pc    = halt_pc_q;
    assign issued_cnt = issued_q;
    assign cycle_cnt  = cycle_q;

endmodule

// File: doc/instr_injector.md
Name: instr_injector

Overview:
- Hardware counterpart of the CPU's injection port: buffers host-loaded 16-bit instructions and drives them into the CPU's instruction input, one per clock, while the CPU runs in injection mode.
- Watches the CPU's halt and PC outputs. Reports completion, or a watchdog timeout if the program never halts.
- Sits between a host/loader and the cpu's instr_in/mode/pc_out/hlt ports.

Parameters:
- DEPTH, 16: instruction FIFO entries; must be a power of two, ≥2.
- IW, 16: instruction width.
- FILL_INSTR, 16'h0000: bubble instruction, ADD R0,R0,R0 (architectural no-op).
- TIMEOUT, 100000: maximum RUN cycles before watchdog trip.
- CW, 17: cycle counter width; must hold TIMEOUT.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rst, input, 1: asynchronous, active-high reset.
- ld_valid, input, 1: host offers ld_instr.
- ld_instr, input, IW: instruction to enqueue.
- ld_ready, output, 1: FIFO can accept an entry.
- start, input, 1: begin injection; sampled only in IDLE.
- clear, input, 1: synchronous flush to IDLE.
- instr_out, output, IW: drives cpu instr_in.
- mode_out, output, 1: drives cpu mode; 1 only in RUN.
- pc_in, input, 16: cpu pc_out; captured at halt.
- hlt_in, input, 1: cpu hlt.
- busy, output, 1: state is RUN.
- done, output, 1: state is HALTED.
- timeout, output, 1: state is TIMEOUT.
- halt_pc, output, 16: pc_in captured on the halt edge.
- issued_cnt, output, 16: real FIFO entries issued since start.
- cycle_cnt, output, CW: RUN cycles elapsed.

Behaviour:
- Reset: state IDLE; FIFO empty. instr_out=FILL_INSTR. mode_out, busy, done and timeout all 0. halt_pc, issued_cnt and cycle_cnt all 0.
- FIFO:
  - Circular buffer with wrapping read/write pointers and an occupancy count of log2(DEPTH)+1 bits.
  - ld_ready = !full. It is combinational from occupancy and may be high in any state.
  - Push occurs when ld_valid && ld_ready.
  - When full, push is refused even if a pop happens in the same cycle.
  - Push and pop in the same cycle when not full: occupancy unchanged.
- States: IDLE, RUN, HALTED, TIMEOUT. All outputs are registered.
- IDLE:
  - start && !empty moves to RUN next cycle. cycle_cnt and issued_cnt clear.
  - start while the FIFO is empty is ignored.
- RUN, each posedge, first matching rule wins:
  - (a) clear: go to IDLE.
  - (b) hlt_in: go to HALTED. halt_pc <= pc_in, instr_out <= FILL_INSTR, no pop.
  - (c) cycle_cnt == TIMEOUT-1: go to TIMEOUT, instr_out <= FILL_INSTR.
  - (d) Otherwise, if !empty: instr_out <= FIFO head, pop, issued_cnt+1. If empty: instr_out <= FILL_INSTR (bubble); stay in RUN.
  - cycle_cnt+1 on every RUN cycle, saturating at TIMEOUT.
- Injection latency: the first instruction appears on instr_out 1 cycle after the start edge. mode_out rises on that same edge.
- HALTED and TIMEOUT:
  - instr_out holds FILL_INSTR.
  - Remaining FIFO entries are retained and loading stays allowed.
  - clear returns to IDLE. start is ignored.
- clear from any state: FIFO flushed, counters cleared, outputs set to their reset values. This takes priority over a push in the same cycle.
- Asynchronous rst mid-RUN: immediate return to reset values; FIFO contents discarded.
- issued_cnt wraps modulo 2^16.

Test Plan:
- Reset: assert rst mid-clock → all outputs at reset values immediately, ld_ready=1, instr_out=16'h0000.
- Basic run: load 16'hB151 then 16'hA151, pulse start, hlt_in=0 → instr_out=B151 at cycle+1, A151 at +2, 0000 at +3 onward. issued_cnt=2, mode_out=1, busy=1.
- Full FIFO: push 16 entries → ld_ready=0. A 17th ld_valid with 16'hF000 is not stored. After start, exactly 16 entries are issued, then FILL_INSTR.
- Halt: load 4 entries, start, pc_in=16'h0004, assert hlt_in after the 2nd issue → done=1, halt_pc=0004, issued_cnt=2, instr_out=0000. clear → IDLE, FIFO empty.
- Watchdog (TIMEOUT=10): load 1 entry, start, never assert hlt → timeout=1 on the 10th RUN cycle, cycle_cnt=10, instr_out=0000, busy=0.
- Simultaneous push/pop: during RUN with 3 entries, hold ld_valid every cycle → occupancy stays 3 and issue order matches push order across pointer wrap-around.
